// File: rtl/alu_op_pkg.sv
// Shared opcodes, legality check and FSM encoding for the ALU op issuer.
// Optional ALU_CHECK_EN enables the reference-model result check.
package alu_op_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RESP
  } state_e;

  function automatic logic is_legal_op(
    input logic [2:0] op
  );
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT};
  endfunction

endpackage

// File: rtl/alu_op_issuer_ref.sv
// Combinational expected-result model of the TotalALU.
// Used by alu_op_issuer when ALU_CHECK_EN is defined.
module alu_ref_model
  import alu_op_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] out_o
);

  logic slt;

  assign slt = $signed(a_i) < $signed(b_i);

  always_comb begin
    out_o = '0;
    unique case (1'b1)
      (op_i == OP_AND): out_o = a_i & b_i;
      (op_i == OP_OR):  out_o = a_i | b_i;
      (op_i == OP_ADD): out_o = a_i + b_i;
      (op_i == OP_SUB): out_o = a_i - b_i;
      (op_i == OP_SLT): out_o = {{(WIDTH-1){1'b0}}, slt};
      default:          out_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_issuer.sv
// Handshaked driver for the combinational TotalALU: issue, settle, respond.
// Define ALU_CHECK_EN to compare the ALU result against alu_ref_model.
module alu_op_issuer
  import alu_op_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [2:0]       cmd_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_signal,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_zero,
  output logic [2:0]       rsp_op,
  output logic             rsp_err,
  output logic             rsp_mismatch,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [3:0] SET_INIT = 4'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       sig_q, sig_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic [2:0]       op_q, op_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] ops_q, ops_d;
  logic             take_ill;
  logic             capture;

  assign take_ill = (state_q == ST_IDLE) & cmd_valid & ~is_legal_op(cmd_op);
  assign capture  = (state_q == ST_SETTLE) & (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    zero_d  = zero_q;
    op_d    = op_q;
    err_d   = err_q;
    ops_d   = ops_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && is_legal_op(cmd_op)) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          sig_d   = cmd_op;
          cnt_d   = SET_INIT;
          state_d = ST_SETTLE;
        end else if (cmd_valid) begin
          out_d   = '0;
          zero_d  = 1'b1;
          op_d    = cmd_op;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_SETTLE: begin
        if (capture) begin
          out_d   = alu_out;
          zero_d  = (alu_out == '0);
          op_d    = sig_q;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          ops_d   = ops_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sig_q   <= 3'b000;
      cnt_q   <= '0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      op_q    <= 3'b000;
      err_q   <= 1'b0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      op_q    <= op_d;
      err_q   <= err_d;
      ops_q   <= ops_d;
    end
  end

`ifdef ALU_CHECK_EN
  logic [WIDTH-1:0] exp_w;
  logic             mis_q;

  alu_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a_i   (a_q),
    .b_i   (b_q),
    .op_i  (sig_q),
    .out_o (exp_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (capture) begin
      mis_q <= (alu_out != exp_w);
    end else if (take_ill) begin
      mis_q <= 1'b0;
    end
  end

  assign rsp_mismatch = mis_q;
`else
  assign rsp_mismatch = 1'b0;
`endif

  assign cmd_ready  = (state_q == ST_IDLE) & ~rst;
  assign rsp_valid  = (state_q == ST_RESP);
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_signal = sig_q;
  assign rsp_out    = out_q;
  assign rsp_zero   = zero_q;
  assign rsp_op     = op_q;
  assign rsp_err    = err_q;
  assign op_count   = ops_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer with a behavioural ALU and fault stub.
module tb_alu_op_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_a, cmd_b;
  logic [2:0]  cmd_op;
  logic [3:0]  alu_a, alu_b;
  logic [2:0]  alu_signal;
  logic [3:0]  alu_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_out;
  logic        rsp_zero;
  logic [2:0]  rsp_op;
  logic        rsp_err;
  logic        rsp_mismatch;
  logic [15:0] op_count;

  logic        stub_zero;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_cnt = 0;
  int          lat;
  logic        exp_mis;

  always #5 clk = ~clk;

  alu_op_issuer #(
    .WIDTH(4), .SETTLE_CYCLES(2), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_signal(alu_signal),
    .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_zero(rsp_zero), .rsp_op(rsp_op),
    .rsp_err(rsp_err), .rsp_mismatch(rsp_mismatch),
    .op_count(op_count)
  );

  // TotalALU stand-in; stub_zero breaks ADD to provoke a mismatch
  always_comb begin
    alu_out = 4'h0;
    case (alu_signal)
      3'b000: alu_out = alu_a & alu_b;
      3'b001: alu_out = alu_a | alu_b;
      3'b010: alu_out = stub_zero ? 4'h0 : alu_a + alu_b;
      3'b110: alu_out = alu_a - alu_b;
      3'b111: alu_out = {3'b000, $signed(alu_a) < $signed(alu_b)};
      default: alu_out = 4'h0;
    endcase
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic issue(
    input  logic [2:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output int         lt
  );
    int guard;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    guard     = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("accept", 32'(guard < 20), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    lt = 1;
    while (!rsp_valid && lt < 40) begin
      @(posedge clk);
      #1;
      lt++;
    end
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
    exp_cnt++;
    check("drain_valid", 32'(rsp_valid), 32'd0);
    check("op_count", 32'(op_count), 32'(exp_cnt));
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_a = 4'h0;
    cmd_b = 4'h0;
    cmd_op = 3'b000;
    rsp_ready = 1'b1;
    stub_zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_sig", 32'(alu_signal), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_ready", 32'(cmd_ready), 32'd1);

    // ADD 0010+1100
    issue(3'b010, 4'b0010, 4'b1100, lat);
    check("add_lat", 32'(lat), 32'd3);
    check("add_sig", 32'(alu_signal), 32'b010);
    check("add_out", 32'(rsp_out), 32'b1110);
    check("add_zero", 32'(rsp_zero), 32'd0);
    check("add_op", 32'(rsp_op), 32'b010);
    check("add_err", 32'(rsp_err), 32'd0);
    drain();

    issue(3'b110, 4'b1011, 4'b0010, lat);
    check("sub_out", 32'(rsp_out), 32'b1001);
    drain();
    issue(3'b010, 4'b1000, 4'b1111, lat);
    check("addc_out", 32'(rsp_out), 32'b0111);
    drain();

    issue(3'b111, 4'b0010, 4'b0101, lat);
    check("slt1_out", 32'(rsp_out), 32'b0001);
    check("slt1_zero", 32'(rsp_zero), 32'd0);
    drain();
    issue(3'b111, 4'b0111, 4'b1000, lat);
    check("slt2_out", 32'(rsp_out), 32'b0000);
    check("slt2_zero", 32'(rsp_zero), 32'd1);
    drain();

    // AND with consumer stalled for 5 cycles
    rsp_ready = 1'b0;
    issue(3'b000, 4'b1110, 4'b0101, lat);
    check("and_out", 32'(rsp_out), 32'b0100);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_out", 32'(rsp_out), 32'b0100);
      check("stall_ready", 32'(cmd_ready), 32'd0);
    end
    check("stall_count", 32'(op_count), 32'(exp_cnt));
    rsp_ready = 1'b1;
    drain();
    issue(3'b001, 4'b1011, 4'b0000, lat);
    check("or_out", 32'(rsp_out), 32'b1011);
    drain();

    // illegal opcode
    issue(3'b100, 4'b0101, 4'b0101, lat);
    check("ill_lat", 32'(lat), 32'd1);
    check("ill_err", 32'(rsp_err), 32'd1);
    check("ill_out", 32'(rsp_out), 32'd0);
    check("ill_zero", 32'(rsp_zero), 32'd1);
    check("ill_op", 32'(rsp_op), 32'b100);
    check("ill_sig", 32'(alu_signal), 32'b001);
    check("ill_mis", 32'(rsp_mismatch), 32'd0);
    drain();

    // reset during SETTLE
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 3'b010;
    cmd_a = 4'h3;
    cmd_b = 4'h4;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("pre_rst_sig", 32'(alu_signal), 32'b010);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst_ready", 32'(cmd_ready), 32'd0);
    check("mrst_alu_a", 32'(alu_a), 32'd0);
    check("mrst_alu_sig", 32'(alu_signal), 32'd0);
    check("mrst_count", 32'(op_count), 32'd0);
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mrst_no_rsp", 32'(rsp_valid), 32'd0);
    check("mrst_idle", 32'(cmd_ready), 32'd1);

    // faulty ALU on ADD
`ifdef ALU_CHECK_EN
    exp_mis = 1'b1;
`else
    exp_mis = 1'b0;
`endif
    stub_zero = 1'b1;
    issue(3'b010, 4'b0001, 4'b0001, lat);
    check("stub_out", 32'(rsp_out), 32'd0);
    check("stub_mis", 32'(rsp_mismatch), 32'(exp_mis));
    drain();
    stub_zero = 1'b0;
    issue(3'b010, 4'b0001, 4'b0001, lat);
    check("good_out", 32'(rsp_out), 32'b0010);
    check("good_mis", 32'(rsp_mismatch), 32'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
